// File: rtl/phase_timer_scheduler_pkg.sv
// Shared codes for the phase timer scheduler: timing tables, light codes,
// scheduler states and the table arbitration rule.
package phase_timer_scheduler_pkg;

  localparam int CLK_HZ_DEFAULT = 10000;

  typedef enum logic [1:0] {
    TBL_A = 2'b00,
    TBL_B = 2'b01,
    TBL_C = 2'b10,
    TBL_D = 2'b11
  } table_t;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'b00,
    LIGHT_YELLOW = 2'b01,
    LIGHT_GREEN  = 2'b10,
    LIGHT_OFF    = 2'b11
  } light_t;

  typedef enum logic [1:0] {
    ST_OFF     = 2'b00,
    ST_DONE    = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_RUN     = 2'b11
  } sched_state_t;

  // Exactly one active sensor selects its table; none or several fall back to A.
  function automatic table_t table_select(input logic snn, input logic sns, input logic sth);
    table_t sel;
    sel = TBL_A;
    if (sth && !snn && !sns) sel = TBL_B;
    else if (snn && !sns && !sth) sel = TBL_C;
    else if (sns && !snn && !sth) sel = TBL_D;
    return sel;
  endfunction

endpackage

// File: rtl/phase_timer_scheduler_sensor_debounce.sv
// Two-flop synchronizer followed by a stability-counter debouncer for one
// raw asynchronous vehicle sensor.
module sensor_debounce
  import phase_timer_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic            meta;
  logic            sync;
  logic            sync_prev;
  logic [CW-1:0]   stable_cnt;

  // sync_prev holds the level the counter is currently timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta       <= 1'b0;
      sync       <= 1'b0;
      sync_prev  <= 1'b0;
      stable_cnt <= '0;
      level      <= 1'b0;
    end else begin
      meta      <= raw;
      sync      <= meta;
      sync_prev <= sync;
      if (sync != sync_prev) stable_cnt <= '0;
      else if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + CW'(1);
      if (stable_cnt == CNT_MAX) level <= sync_prev;
    end
  end

endmodule

// File: rtl/phase_timer_scheduler.sv
// Phase timer for the light sequencer: counts whole seconds of each phase,
// pulses finished between phases and picks the timing table from the sensors.
module phase_timer_scheduler
  import phase_timer_scheduler_pkg::*;
#(
  parameter int CLK_HZ       = CLK_HZ_DEFAULT,
  parameter int DEBOUNCE_CYC = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_general,
  input  logic        snn,
  input  logic        sns,
  input  logic        sth,
  input  logic [15:0] seconds_to_count,
  output logic        finished,
  output logic [1:0]  tabla,
  output logic [15:0] remaining,
  output logic        second_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  sched_state_t  state_q;
  sched_state_t  state_d;
  logic [PW-1:0] presc;
  table_t        tabla_q;
  logic          deb_snn;
  logic          deb_sns;
  logic          deb_sth;

  sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_snn (
    .clk(clk), .reset(reset), .raw(snn), .level(deb_snn)
  );
  sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_sns (
    .clk(clk), .reset(reset), .raw(sns), .level(deb_sns)
  );
  sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_sth (
    .clk(clk), .reset(reset), .raw(sth), .level(deb_sth)
  );

  assign finished    = (state_q == ST_DONE);
  assign second_tick = enable_general && (state_q == ST_RUN) && (presc == PRESC_MAX);
  assign tabla       = tabla_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_DONE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF:     state_d = ST_DONE;
      ST_DONE:    state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = (seconds_to_count != 16'd0) ? ST_RUN : ST_DONE;
      ST_RUN:     if (second_tick && remaining <= 16'd1) state_d = ST_DONE;
      default:    state_d = ST_OFF;
    endcase
    if (!enable_general) state_d = ST_OFF;
  end

  // The sequencer updates seconds_to_count on the finished edge, so it is
  // sampled in CAPTURE, never earlier.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= 16'd0;
      presc     <= '0;
      tabla_q   <= TBL_A;
    end else if (!enable_general) begin
      remaining <= 16'd0;
      presc     <= '0;
    end else begin
      unique case (state_q)
        ST_DONE: tabla_q <= table_select(deb_snn, deb_sns, deb_sth);
        ST_CAPTURE: begin
          remaining <= seconds_to_count;
          presc     <= '0;
        end
        ST_RUN: begin
          presc <= second_tick ? '0 : presc + PW'(1);
          if (second_tick) remaining <= (remaining > 16'd1) ? remaining - 16'd1 : 16'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_timer_scheduler.sv
// Randomized scoreboard bench for phase_timer_scheduler with directed
// reset, enable-drop and reset-mid-phase sequences.
module tb_phase_timer_scheduler;

  localparam int P_CLK = 10;
  localparam int P_DEB = 4;
  localparam int NPH   = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_general;
  logic        snn, sns, sth;
  logic [15:0] seconds_to_count;
  logic        finished;
  logic [1:0]  tabla;
  logic [15:0] remaining;
  logic        second_tick;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         n;
    logic [1:0] tbl;
  } exp_t;
  exp_t exp_q[$];

  bit       mon_en = 1'b0;
  bit [2:0] cur_sens = 3'b000;

  phase_timer_scheduler #(.CLK_HZ(P_CLK), .DEBOUNCE_CYC(P_DEB)) dut (
    .clk(clk), .reset(reset), .enable_general(enable_general),
    .snn(snn), .sns(sns), .sth(sth), .seconds_to_count(seconds_to_count),
    .finished(finished), .tabla(tabla), .remaining(remaining),
    .second_tick(second_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Table chosen from a settled sensor pattern {snn, sns, sth}.
  function automatic logic [1:0] model_table(input bit [2:0] s);
    int ones;
    ones = s[0] + s[1] + s[2];
    if (ones != 1) return 2'b00;
    if (s[0]) return 2'b01;
    if (s[2]) return 2'b10;
    return 2'b11;
  endfunction

  // Seconds left k cycles after a finished pulse of an n-second phase.
  function automatic int model_rem(input int n, input int k);
    if (k < 2) return 0;
    return n - (k - 2) / P_CLK;
  endfunction

  function automatic bit model_tick(input int n, input int k);
    return (k >= 2) && (k <= n * P_CLK + 1) && ((k - 2) % P_CLK == P_CLK - 1);
  endfunction

  task automatic drive_sens(input bit [2:0] v);
    snn = v[2];
    sns = v[1];
    sth = v[0];
  endtask

  task automatic wait_fin();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!finished && i < 200);
    if (!finished) begin
      checks++;
      failures++;
      $display("FAIL finished_timeout actual=0 required=1 at %0t", $time);
    end
  endtask

  // Monitor: k counts cycles since the last finished pulse; the expectation
  // for the phase is popped on the CAPTURE cycle.
  initial begin : monitor
    bit   have;
    int   k;
    exp_t it;
    have = 1'b0;
    k    = 0;
    it.n = 0;
    it.tbl = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en) begin
        have = 1'b0;
      end else if (!have) begin
        if (finished) begin
          have = 1'b1;
          k    = 0;
        end
      end else begin
        k++;
        if (k == 1) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty actual=0 required=1 at %0t", $time);
          end else begin
            it = exp_q.pop_front();
          end
        end
        check("sb_finished", finished, (k == it.n * P_CLK + 2) ? 1 : 0);
        check("sb_remaining", remaining, model_rem(it.n, k));
        check("sb_tick", second_tick, model_tick(it.n, k) ? 1 : 0);
        check("sb_tabla", tabla, it.tbl);
        if (finished) k = 0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    bit [2:0] nv;
    int b;
    reset            = 1'b1;
    enable_general   = 1'b1;
    seconds_to_count = 16'd3;
    drive_sens(3'b000);
    repeat (3) @(negedge clk);

    // Reset release followed by one 3-second phase, cycle 0 = first DONE.
    reset = 1'b0;
    check("rst_finished", finished, 1);
    check("rst_remaining", remaining, 0);
    check("rst_tabla", tabla, 0);
    check("rst_tick", second_tick, 0);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      check("p3_finished", finished, (k == 32) ? 1 : 0);
      check("p3_tick", second_tick, (k == 11 || k == 21 || k == 31) ? 1 : 0);
      check("p3_remaining", remaining, model_rem(3, k));
    end

    // Enable dropped while two seconds remain.
    repeat (15) @(negedge clk);
    check("en_rem_before", remaining, 2);
    enable_general = 1'b0;
    @(negedge clk);
    check("en_off_finished", finished, 0);
    check("en_off_remaining", remaining, 0);
    check("en_off_tick", second_tick, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("en_off_hold", {finished, second_tick, remaining}, 0);
    end
    enable_general = 1'b1;
    @(negedge clk);
    check("en_on_finished", finished, 1);
    @(negedge clk);
    check("en_capture_finished", finished, 0);
    check("en_capture_rem", remaining, 0);
    @(negedge clk);
    check("en_run_rem", remaining, 3);

    // Randomized phases under the scoreboard.
    mon_en = 1'b1;
    for (int p = 0; p < NPH; p++) begin
      wait_fin();
      n = $urandom_range(0, 3);
      exp_q.push_back('{n: n, tbl: model_table(cur_sens)});
      seconds_to_count = 16'(n);
      if (n >= 1) begin
        nv = 3'($urandom_range(0, 7));
        drive_sens(nv);
        cur_sens = nv;
        repeat (5) @(negedge clk);
        seconds_to_count = 16'($urandom_range(0, 65535));
      end
      if (n >= 2) begin
        repeat (7) @(negedge clk);
        b = $urandom_range(0, 2);
        drive_sens(cur_sens ^ 3'(1 << b));
        repeat (2) @(negedge clk);
        drive_sens(cur_sens);
      end
    end
    wait_fin();
    mon_en = 1'b0;

    // Table C established, then reset in the middle of a phase.
    seconds_to_count = 16'd2;
    drive_sens(3'b100);
    cur_sens = 3'b100;
    wait_fin();
    @(negedge clk);
    check("snn_tabla_c", tabla, 2);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("midrst_finished", finished, 1);
    check("midrst_tabla", tabla, 0);
    check("midrst_remaining", remaining, 0);
    check("midrst_tick", second_tick, 0);
    @(negedge clk);
    check("midrst_capture", finished, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_timer_scheduler.md
PHASE_TIMER_SCHEDULER -- requirements
Module: phase_timer_scheduler

Interface
REQ-001 Parameter CLK_HZ, default 10000, clk cycles per second (1-second prescaler terminal count).
REQ-002 Parameter DEBOUNCE_CYC, default 500, cycles a synchronized sensor must hold its level before the debounced value changes.
REQ-003 clk  in  1  system clock, 10 kHz nominal; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable_general  in  1  system enable; low means lights off and timer halted.
REQ-006 snn, sns, sth  in  1 each  raw asynchronous vehicle sensors: Norton-north, Norton-south and Thevenin.
REQ-007 seconds_to_count  in  16  phase duration in seconds, driven by the light sequencer.
REQ-008 finished  out  1  one-cycle pulse; the sequencer shall advance one phase per pulse.
REQ-009 tabla  out  2  timing-table select: A=00, B=01, C=10, D=11.
REQ-010 remaining  out  16  seconds left in the current phase.
REQ-011 second_tick  out  1  one-cycle pulse per elapsed second while running.

Function
REQ-012 States: OFF, DONE, CAPTURE, RUN; state register only, finished = (state==DONE).
REQ-013 DONE -> CAPTURE unconditionally after one cycle.
REQ-014 In CAPTURE, remaining and the phase value shall load seconds_to_count as it stands that cycle, so the sequencer's update made on the finished edge is seen; the prescaler clears to 0.
REQ-015 CAPTURE -> RUN if the captured value != 0; otherwise CAPTURE -> DONE, with remaining staying 0.
REQ-016 RUN: the prescaler counts 0..CLK_HZ-1 and wraps; second_tick = 1 on the cycle the prescaler equals CLK_HZ-1.
REQ-017 On a second_tick with remaining > 1, remaining shall decrement by 1.
REQ-018 On a second_tick with remaining == 1, remaining becomes 0 and the state goes to DONE.
REQ-019 Phase period, finished pulse to finished pulse, shall be exactly N*CLK_HZ + 2 cycles for N>0 and 2 cycles for N=0.
REQ-020 Each sensor shall pass a 2-flop synchronizer and then a debouncer.
REQ-021 Debouncer: a stability counter resets on any change of the synchronized level; the debounced output takes the new level when the counter reaches DEBOUNCE_CYC-1.
REQ-022 Table arbitration on the debounced sensors: sth-only -> B; snn-only -> C; sns-only -> D; none or more than one active -> A.
REQ-023 tabla shall update only on the cycle the state is DONE, so it is constant for a whole phase.
REQ-024 enable_general low in any state: the next state is OFF, remaining = 0, prescaler = 0, second_tick = 0, finished = 0; tabla holds its value.
REQ-025 OFF -> DONE on the first cycle enable_general is high, giving the sequencer its start pulse.
REQ-026 The debouncers shall keep running while OFF.
REQ-027 Priority: reset > enable_general low > normal transitions.
REQ-028 A seconds_to_count change outside CAPTURE shall have no effect on the running phase.

Reset
REQ-029 reset shall force state = DONE, remaining = 0, prescaler = 0, tabla = A, second_tick = 0.
REQ-030 reset shall clear the debounced outputs to 0 and the stability counters to 0; synchronizer flops are cleared to 0.
REQ-031 Reset mid-RUN shall abandon the phase; the first cycle after release is DONE (finished = 1) if enable_general is high, else OFF.

Structure
REQ-032 A shared package holds the table codes A-D, the light codes (RED=00, YELLOW=01, GREEN=10, OFF=11), the scheduler state encoding and the CLK_HZ default.
REQ-033 One sub-module, sensor_debounce (synchronizer plus stability counter, DEBOUNCE_CYC parameter), instantiated three times.
REQ-034 The prescaler and the remaining counter shall be sized to cover CLK_HZ-1 and 16 bits, with no wrap below 0.

Verification (CLK_HZ=10, DEBOUNCE_CYC=4 unless stated)
REQ-035 Reset released, enable=1, seconds_to_count=3 constant -> finished at cycle 0; remaining 3,2,1,0 with ticks at cycles 11, 21, 31; next finished at cycle 32.
REQ-036 seconds_to_count=0 -> finished pulses every 2 cycles and no second_tick occurs.
REQ-037 sth=1 with others 0, held 6+ cycles -> tabla=B at the next DONE; a 2-cycle sth glitch leaves tabla=A; snn and sns both high -> tabla=A.
REQ-038 enable_general dropped mid-RUN with remaining=2 -> next cycle OFF, remaining=0, finished=0; enable raised -> finished=1 on the following cycle, then CAPTURE.
REQ-039 reset asserted mid-RUN with tabla=C -> after release tabla=A, remaining=0, finished=1 on the first cycle.
REQ-040 seconds_to_count changed from 5 to 9 mid-RUN -> the phase still ends after 5 s; the next phase captures 9.
